// File: rtl/wb_slave_if.sv
// Wishbone B4 pipelined bus bundle between one master and the wb_slave register file.
interface wb_slave_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 8
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic                  we_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  logic                  err_o;
  logic                  stall_o;

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_slave.sv
// Wishbone B4 pipelined slave over a REGISTER_NUM x DATA_WIDTH register file, single-cycle latency.
// Define WB_SLAVE_ERR_EN to answer out-of-range addresses with err_o instead of ack_o.
module wb_slave #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GRANULE      = 8,
  parameter int unsigned REGISTER_NUM = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  wb_slave_if.slave  bus
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int unsigned IDX_LOG   = $clog2(REGISTER_NUM);
  localparam int unsigned IDX_W     = (IDX_LOG == 0) ? 1 : IDX_LOG;

  logic [DATA_WIDTH-1:0] regs_q [REGISTER_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_NUM];
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  stall_q, stall_d;
`ifdef WB_SLAVE_ERR_EN
  logic                  err_q, err_d;
`endif

  logic             accept;
  logic             addr_valid;
  logic [IDX_W-1:0] idx;

  assign accept     = bus.cyc_i & bus.stb_i & ~stall_q;
  assign addr_valid = (bus.adr_i >> IDX_LOG) == '0;
  assign idx        = IDX_W'(bus.adr_i);

  // Request decode: register file update, read data capture and response flags.
  always_comb begin
    regs_d  = regs_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    stall_d = 1'b0;
`ifdef WB_SLAVE_ERR_EN
    err_d   = 1'b0;
`endif
    if (accept) begin
      if (addr_valid) begin
        ack_d = 1'b1;
        if (bus.we_i) begin
          for (int k = 0; k < int'(SEL_WIDTH); k++) begin
            if (bus.sel_i[k]) begin
              regs_d[idx][k*GRANULE +: GRANULE] = bus.dat_i[k*GRANULE +: GRANULE];
            end
          end
        end else begin
          dat_d = regs_q[idx];
        end
      end else begin
`ifdef WB_SLAVE_ERR_EN
        err_d = 1'b1;
`else
        ack_d = 1'b1;
        if (!bus.we_i) begin
          dat_d = '0;
        end
`endif
      end
    end
  end

  // stall_q leaves reset high so the first edge after release accepts nothing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(REGISTER_NUM); i++) begin
        regs_q[i] <= '0;
      end
      dat_q   <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      regs_q  <= regs_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
    end
  end

  assign bus.dat_o   = dat_q;
  assign bus.stall_o = stall_q;
  // A master abandoning the cycle takes the pending response with it.
  assign bus.ack_o   = ack_q & bus.cyc_i;

`ifdef WB_SLAVE_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q & bus.cyc_i;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_slave.sv
// Scoreboard bench for wb_slave: expected responses queued at drive time, popped one cycle later.
module tb_wb_slave;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8)) bus ();

  wb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .REGISTER_NUM(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  logic [DW-1:0] m_regs [16];
  logic [DW-1:0] m_dat;
  int            total = 0;
  int            bad   = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_dat = '0;
    sb.delete();
    sb.push_back('{ack: 1'b0, err: 1'b0, dat: '0});
  endtask

  // Drive one request just after the edge and queue the response it must produce.
  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [3:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    bus.cyc_i = cyc;
    bus.stb_i = stb;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = dat;
    bus.sel_i = sel;
    e.ack = 1'b0;
    e.err = 1'b0;
    if (cyc && stb) begin
      if (adr < 16) begin
        e.ack = 1'b1;
        if (we) begin
          for (int k = 0; k < 4; k++)
            if (sel[k]) m_regs[adr[3:0]][k*8 +: 8] = dat[k*8 +: 8];
        end else begin
          m_dat = m_regs[adr[3:0]];
        end
      end else begin
`ifdef WB_SLAVE_ERR_EN
        e.err = 1'b1;
`else
        e.ack = 1'b1;
        if (!we) m_dat = '0;
`endif
      end
    end
    e.dat = m_dat;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0;   bus.dat_i = '0;   bus.sel_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.ack_o !== 1'b0 || bus.err_o !== 1'b0 || bus.stall_o !== 1'b1 || bus.dat_o !== '0) begin
      bad++;
      $display("FAIL reset_state: ack/err/stall/dat=%b/%b/%b/%h expected 0/0/1/0",
               bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cyc_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL stall_after_release: stall_o=%b expected 1", bus.stall_o);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL stall_settled: stall_o=%b expected 0", bus.stall_o);
    end
    model_clear();
  endtask

  task automatic test_write_read();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       drive(1'b1, 1'b1, 1'b1, 16'd3, 32'hDEADBEEF, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b0, 16'd3, 32'h0, 4'h0);
        default: drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL write_read[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
    end
    total++;
    if (bus.ack_o !== 1'b1 || bus.dat_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_adr3: ack=%b dat=%h expected 1/deadbeef", bus.ack_o, bus.dat_o);
    end
  endtask

  task automatic test_byte_sel();
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      case (s)
        0:       drive(1'b1, 1'b1, 1'b1, 16'd5, 32'h11223344, 4'hF);
        1:       drive(1'b1, 1'b1, 1'b1, 16'd5, 32'hAABBCCDD, 4'h5);
        2:       drive(1'b1, 1'b1, 1'b0, 16'd5, 32'h0, 4'h0);
        4:       drive(1'b1, 1'b1, 1'b1, 16'd5, 32'hFFFFFFFF, 4'h0);
        5:       drive(1'b1, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL byte_sel[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
      if (s == 3 || s == 6) begin
        total++;
        if (bus.dat_o !== 32'h11BB33DD) begin
          bad++; $display("FAIL byte_lanes[%0d]: dat=%h expected 11bb33dd", s, bus.dat_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acks = 0;
    for (int s = 0; s < 33; s++) begin
      if (s < 16)      drive(1'b1, 1'b1, 1'b1, AW'(s), DW'(s), 4'hF);
      else if (s < 32) drive(1'b1, 1'b1, 1'b0, AW'(s - 16), 32'h0, 4'h0);
      else             drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL b2b[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
      if (s >= 1 && bus.ack_o === 1'b1) acks++;
      if (s >= 17) begin
        total++;
        if (bus.dat_o !== DW'(s - 17)) begin
          bad++; $display("FAIL b2b_read[%0d]: dat=%h expected %h", s - 17, bus.dat_o, DW'(s - 17));
        end
      end
    end
    total++;
    if (acks != 32) begin
      bad++; $display("FAIL b2b_ack_count: acks=%0d expected 32", acks);
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0:       drive(1'b1, 1'b1, 1'b0, 16'd16, 32'h0, 4'hF);
        2:       drive(1'b1, 1'b1, 1'b1, 16'h8000, 32'h5A5A5A5A, 4'hF);
        3:       drive(1'b1, 1'b1, 1'b0, 16'h8003, 32'h0, 4'hF);
        4:       drive(1'b1, 1'b1, 1'b0, 16'd0, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL invalid[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
      if (s == 1) begin
        total++;
`ifdef WB_SLAVE_ERR_EN
        if (bus.err_o !== 1'b1 || bus.ack_o !== 1'b0) begin
          bad++; $display("FAIL read_adr16: err=%b ack=%b expected 1/0", bus.err_o, bus.ack_o);
        end
`else
        if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b0 || bus.dat_o !== '0) begin
          bad++; $display("FAIL read_adr16: ack=%b err=%b dat=%h expected 1/0/0", bus.ack_o, bus.err_o, bus.dat_o);
        end
`endif
      end
      if (s == 5) begin
        total++;
        if (bus.dat_o !== 32'h0) begin
          bad++; $display("FAIL alias_write: reg0=%h expected 0", bus.dat_o);
        end
      end
    end
  endtask

  task automatic test_cyc_drop();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       drive(1'b1, 1'b1, 1'b1, 16'd2, 32'hCAFE0002, 4'hF);
        1:       drive(1'b0, 1'b1, 1'b0, 16'd2, 32'h0, 4'hF);
        2:       drive(1'b1, 1'b1, 1'b0, 16'd2, 32'h0, 4'hF);
        default: drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL cyc_drop[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
      if (s == 1) begin
        total++;
        if (bus.ack_o !== 1'b0) begin
          bad++; $display("FAIL dropped_ack: ack=%b expected 0", bus.ack_o);
        end
      end
      if (s == 3) begin
        total++;
        if (bus.dat_o !== 32'hCAFE0002 || bus.ack_o !== 1'b1) begin
          bad++; $display("FAIL write_stands: ack=%b dat=%h expected 1/cafe0002", bus.ack_o, bus.dat_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(1'b1, 1'b1, 1'b0, 16'd7, 32'h0, 4'hF);
    @(negedge clk);
    void'(sb.pop_front());
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.stb_i = 1'b0;
    #1;
    total++;
    if (bus.ack_o !== 1'b0 || bus.dat_o !== '0 || bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_abort: ack/dat/stall=%b/%h/%b expected 0/0/1", bus.ack_o, bus.dat_o, bus.stall_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    model_clear();
    for (int s = 0; s < 17; s++) begin
      if (s < 16) drive(1'b1, 1'b1, 1'b0, AW'(s), 32'h0, 4'hF);
      else        drive(1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.ack_o !== (e.ack & bus.cyc_i) || bus.err_o !== (e.err & bus.cyc_i) ||
          bus.dat_o !== e.dat || bus.stall_o !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_read[%0d]: ack/err/stall/dat=%b/%b/%b/%h expected %b/%b/0/%h",
                 s, bus.ack_o, bus.err_o, bus.stall_o, bus.dat_o, e.ack & bus.cyc_i, e.err & bus.cyc_i, e.dat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_sel();
    test_back_to_back();
    test_invalid();
    test_cyc_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_slave.md
WB_SLAVE -- requirements
Module: wb_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of adr_i.
REQ-002 Parameter DATA_WIDTH, default 32, width of dat_i/dat_o; a multiple of GRANULE.
REQ-003 Parameter GRANULE, default 8, bits per byte-select lane.
REQ-004 Parameter REGISTER_NUM, default 16, number of DATA_WIDTH registers; a power of two, at most 2^ADDR_WIDTH.
REQ-005 Localparam SEL_WIDTH = DATA_WIDTH/GRANULE (default 4).
REQ-006 The block has one clock, and its reset is asynchronous and active-high.
REQ-007 clk_i  in  1  clock; all state changes on the rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 adr_i  in  ADDR_WIDTH  word address (register index, not byte address).
REQ-010 dat_i  in  DATA_WIDTH  write data.
REQ-011 dat_o  out  DATA_WIDTH  read data.
REQ-012 sel_i  in  SEL_WIDTH  byte-lane enables; bit k covers dat bits [k*GRANULE +: GRANULE].
REQ-013 we_i  in  1  1 = write, 0 = read.
REQ-014 stb_i  in  1  request strobe.
REQ-015 ack_o  out  1  successful termination.
REQ-016 err_o  out  1  error termination.
REQ-017 stall_o  out  1  slave cannot accept a request this cycle.
REQ-018 cyc_i  in  1  bus cycle valid.

Function
REQ-019 The block SHALL implement a Wishbone B4 pipelined slave in front of a register file of REGISTER_NUM x DATA_WIDTH registers.
REQ-020 A request SHALL be accepted on a rising edge where cyc_i=1, stb_i=1 and stall_o=0.
REQ-021 Each accepted request SHALL get exactly one one-cycle response (ack_o or err_o, never both) in the next cycle; latency is 1 clock.
REQ-022 The block SHALL accept one request per cycle back-to-back, so the response to request N coincides with the acceptance of request N+1.
REQ-023 A write to a valid address SHALL, at the accepting edge, update only the byte lanes whose sel_i bit is 1; sel_i=0 SHALL still ack without changing the register.
REQ-024 A read from a valid address SHALL load dat_o with the full register word (sel_i ignored) at the accepting edge; dat_o SHALL hold that value until the next accepted read.
REQ-025 An address is valid when adr_i < REGISTER_NUM, including all upper bits.
REQ-026 stall_o SHALL be 1 in reset and on the first edge after rst_i deasserts, and 0 afterwards.
REQ-027 If cyc_i=0 at the edge where a response is due, the pending response SHALL be dropped (ack_o=err_o=0), though a write already performed SHALL stand.
REQ-028 When stb_i=0 or cyc_i=0, there SHALL be no register change and no response.

Reset
REQ-029 While rst_i=1, all registers and dat_o SHALL be 0, ack_o=0, err_o=0, stall_o=1, and any pending response SHALL be cleared.
REQ-030 Asserting rst_i mid-transaction SHALL abort it immediately with no response.

Configuration
REQ-031 With macro WB_SLAVE_ERR_EN defined, an accepted request to an invalid address SHALL respond with err_o=1, no register change, and dat_o unchanged.
REQ-032 Without WB_SLAVE_ERR_EN, err_o SHALL be tied to 0, and an invalid-address request SHALL ack; writes to it are ignored and reads load dat_o=0.

Verification
REQ-033 Reset pulse, then write adr=3, dat=0xDEADBEEF, sel=0xF -> ack_o one cycle later; a read of adr=3 -> ack_o with dat_o=0xDEADBEEF.
REQ-034 Register 5 holds 0x11223344; write dat=0xAABBCCDD with sel=0x5 -> a read of adr=5 returns 0x11BB33DD.
REQ-035 Back-to-back writes to adr 0..15 with dat=index, then back-to-back reads of 0..15 -> 16 consecutive acks, dat_o equal to the index each cycle, stall_o=0 throughout.
REQ-036 A read of adr=16 -> err_o=1, ack_o=0 with WB_SLAVE_ERR_EN; without it, ack_o=1 and dat_o=0.
REQ-037 Write adr=2 is accepted, then cyc_i is dropped in the response cycle -> no ack_o, and a later read of adr=2 returns the written data.
REQ-038 rst_i is asserted while a read is pending -> ack_o stays 0, dat_o=0, and all registers read back 0 after reset.
